// File: rtl/fb_pkg.sv
// Shared types for the fragment writer: framebuffer geometry,
// the buffered write word and the writer FSM states.
package fb_pkg;

  localparam int COLOR_WIDTH = 16;
  localparam int FB_WIDTH    = 640;
  localparam int FB_HEIGHT   = 480;
  localparam int ADDR_WIDTH  = 19;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]  addr;
    logic [COLOR_WIDTH-1:0] color;
  } fb_word_t;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    ACTIVE,
    DRAIN
  } writer_state_t;

endpackage

// File: rtl/fragment_fifo.sv
// Synchronous FIFO of framebuffer words. A push into a full FIFO
// is accepted only when a pop happens in the same cycle.
module fragment_fifo
  import fb_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  fb_word_t               i_data,
  output fb_word_t               o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  fb_word_t        r_mem [DEPTH];
  logic [AW-1:0]   r_wr;
  logic [AW-1:0]   r_rd;
  logic [AW:0]     r_count;
  logic            w_push;
  logic            w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd];

  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      if (w_push && !w_pop)
        r_count <= r_count + 1'b1;
      else if (w_pop && !w_push)
        r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

endmodule

// File: rtl/fragment_writer.sv
// Flat-shades rasterizer fragments and writes them to the framebuffer.
// Optional write/drop counters: define FRAGMENT_WRITER_STATS_EN.
module fragment_writer #(
  parameter int CORD_WIDTH  = 10,
  parameter int COLOR_WIDTH = fb_pkg::COLOR_WIDTH,
  parameter int FB_WIDTH    = fb_pkg::FB_WIDTH,
  parameter int FB_HEIGHT   = fb_pkg::FB_HEIGHT,
  parameter int FIFO_DEPTH  = 16,
  parameter int ADDR_WIDTH  = fb_pkg::ADDR_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_tri_start,
  input  logic [COLOR_WIDTH-1:0]  i_color0,
  input  logic [COLOR_WIDTH-1:0]  i_color1,
  input  logic [COLOR_WIDTH-1:0]  i_color2,
  input  logic                    i_frag_valid,
  input  logic [CORD_WIDTH-1:0]   i_frag_x,
  input  logic [CORD_WIDTH-1:0]   i_frag_y,
  input  logic [2*CORD_WIDTH:0]   i_lambda0,
  input  logic [2*CORD_WIDTH:0]   i_lambda1,
  input  logic [2*CORD_WIDTH:0]   i_lambda2,
  input  logic                    i_raster_done,
  output logic                    o_mem_valid,
  output logic [ADDR_WIDTH-1:0]   o_mem_addr,
  output logic [COLOR_WIDTH-1:0]  o_mem_data,
  input  logic                    i_mem_ready,
  output logic                    o_busy,
  output logic                    o_done,
`ifdef FRAGMENT_WRITER_STATS_EN
  output logic [15:0]             o_written_count,
  output logic [15:0]             o_dropped_count,
`endif
  output logic                    o_overflow
);

  import fb_pkg::*;

  localparam int LW = 2*CORD_WIDTH + 1;

  writer_state_t          r_state;
  writer_state_t          w_next;
  logic [COLOR_WIDTH-1:0] r_c0, r_c1, r_c2;
  logic                   r_valid;
  fb_word_t               r_out;
  logic                   r_done;
  logic                   r_ovf;

  logic [LW-1:0]          w_a0, w_a1, w_a2;
  logic [COLOR_WIDTH-1:0] w_color;
  logic [31:0]            w_addr_full;
  logic                   w_inb;
  logic                   w_take;
  logic                   w_pop;
  logic                   w_drop;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_start;
  logic                   w_fin;
  logic                   w_hs;
  fb_word_t               w_push_word;
  fb_word_t               w_fifo_q;
  logic [$clog2(FIFO_DEPTH):0] w_count;

  assign w_a0 = i_lambda0[LW-1] ? -i_lambda0 : i_lambda0;
  assign w_a1 = i_lambda1[LW-1] ? -i_lambda1 : i_lambda1;
  assign w_a2 = i_lambda2[LW-1] ? -i_lambda2 : i_lambda2;

  // Dominant vertex; ">=" keeps ties on the lower index.
  always_comb begin
    w_color = r_c2;
    if (w_a0 >= w_a1 && w_a0 >= w_a2)
      w_color = r_c0;
    else if (w_a1 >= w_a2)
      w_color = r_c1;
  end

  assign w_addr_full = 32'(i_frag_y) * 32'(FB_WIDTH)
                     + 32'(i_frag_x);
  assign w_inb = (int'(i_frag_x) < FB_WIDTH)
              && (int'(i_frag_y) < FB_HEIGHT);

  assign w_push_word.addr  = w_addr_full[ADDR_WIDTH-1:0];
  assign w_push_word.color = w_color;

  assign w_take = i_frag_valid && w_inb
               && (r_state == ARM || r_state == ACTIVE);
  assign w_hs   = r_valid && i_mem_ready;
  assign w_pop  = !w_empty && (!r_valid || i_mem_ready);
  assign w_drop = w_take && w_full && !w_pop;

  fragment_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_take),
    .i_pop   (w_pop),
    .i_data  (w_push_word),
    .o_data  (w_fifo_q),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign w_start = (r_state == IDLE) && i_tri_start;
  assign w_fin   = (r_state == DRAIN) && w_empty && !r_valid;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:   if (i_tri_start)    w_next = ARM;
      ARM:    if (!i_raster_done) w_next = ACTIVE;
      ACTIVE: if (i_raster_done)  w_next = DRAIN;
      DRAIN:  if (w_fin)          w_next = IDLE;
      default:                    w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_c0    <= '0;
      r_c1    <= '0;
      r_c2    <= '0;
      r_valid <= 1'b0;
      r_out   <= '0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= w_fin;
      if (w_start) begin
        r_c0 <= i_color0;
        r_c1 <= i_color1;
        r_c2 <= i_color2;
      end
      if (w_start)
        r_ovf <= 1'b0;
      else if (w_drop)
        r_ovf <= 1'b1;
      if (w_pop) begin
        r_valid <= 1'b1;
        r_out   <= w_fifo_q;
      end else if (w_hs) begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef FRAGMENT_WRITER_STATS_EN
  logic [15:0] r_wr_cnt;
  logic [15:0] r_dr_cnt;

  always_ff @(posedge clk) begin
    if (rst || w_start) begin
      r_wr_cnt <= '0;
      r_dr_cnt <= '0;
    end else begin
      if (w_hs && r_wr_cnt != 16'hFFFF)
        r_wr_cnt <= r_wr_cnt + 1'b1;
      if (w_drop && r_dr_cnt != 16'hFFFF)
        r_dr_cnt <= r_dr_cnt + 1'b1;
    end
  end

  assign o_written_count = r_wr_cnt;
  assign o_dropped_count = r_dr_cnt;
`endif

  assign o_mem_valid = r_valid;
  assign o_mem_addr  = r_out.addr;
  assign o_mem_data  = r_out.color;
  assign o_busy      = (r_state != IDLE);
  assign o_done      = r_done;
  assign o_overflow  = r_ovf;

endmodule

// File: tb/tb_fragment_writer.sv
// Directed bench for fragment_writer: expected writes are queued
// from a pixel-level model and checked on every memory handshake.
module tb_fragment_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_tri_start;
  logic [15:0] i_color0, i_color1, i_color2;
  logic        i_frag_valid;
  logic [9:0]  i_frag_x, i_frag_y;
  logic [20:0] i_lambda0, i_lambda1, i_lambda2;
  logic        i_raster_done;
  logic        o_mem_valid;
  logic [18:0] o_mem_addr;
  logic [15:0] o_mem_data;
  logic        i_mem_ready;
  logic        o_busy, o_done, o_overflow;
`ifdef FRAGMENT_WRITER_STATS_EN
  logic [15:0] o_written_count, o_dropped_count;
`endif

  fragment_writer dut (
    .clk           (clk),
    .rst           (rst),
    .i_tri_start   (i_tri_start),
    .i_color0      (i_color0),
    .i_color1      (i_color1),
    .i_color2      (i_color2),
    .i_frag_valid  (i_frag_valid),
    .i_frag_x      (i_frag_x),
    .i_frag_y      (i_frag_y),
    .i_lambda0     (i_lambda0),
    .i_lambda1     (i_lambda1),
    .i_lambda2     (i_lambda2),
    .i_raster_done (i_raster_done),
    .o_mem_valid   (o_mem_valid),
    .o_mem_addr    (o_mem_addr),
    .o_mem_data    (o_mem_data),
    .i_mem_ready   (i_mem_ready),
    .o_busy        (o_busy),
    .o_done        (o_done),
`ifdef FRAGMENT_WRITER_STATS_EN
    .o_written_count (o_written_count),
    .o_dropped_count (o_dropped_count),
`endif
    .o_overflow    (o_overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [18:0] a;
    logic [15:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [15:0] m_c0, m_c1, m_c2;

  function automatic void chk(string name,
                              logic [63:0] act,
                              logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endfunction

  function automatic logic [15:0] m_shade(int l0, int l1, int l2);
    int a0, a1, a2;
    a0 = (l0 < 0) ? -l0 : l0;
    a1 = (l1 < 0) ? -l1 : l1;
    a2 = (l2 < 0) ? -l2 : l2;
    if (a0 >= a1 && a0 >= a2) return m_c0;
    if (a1 >= a2) return m_c1;
    return m_c2;
  endfunction

  // Compare process: every handshake must match the next expected write.
  logic        stall_prev = 1'b0;
  logic [18:0] prev_a;
  logic [15:0] prev_d;
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev)
        chk("stall_hold", {o_mem_valid, o_mem_addr, o_mem_data},
            {1'b1, prev_a, prev_d});
      if (o_mem_valid && i_mem_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {o_mem_addr, o_mem_data}, 0);
          if (o_mem_addr == 0 && o_mem_data == 0) begin
            n_fail++;
            $display("FAIL unexpected_write: got 0 expected none");
          end
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("write", {o_mem_addr, o_mem_data}, {e.a, e.d});
        end
      end
      stall_prev = o_mem_valid && !i_mem_ready;
      prev_a = o_mem_addr;
      prev_d = o_mem_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_tri(logic [15:0] c0, c1, c2);
    i_tri_start   = 1'b1;
    i_color0      = c0;
    i_color1      = c1;
    i_color2      = c2;
    i_raster_done = 1'b1;
    m_c0 = c0; m_c1 = c1; m_c2 = c2;
    step();
    i_tri_start   = 1'b0;
    i_color0      = '0;
    i_color1      = '0;
    i_color2      = '0;
    i_raster_done = 1'b0;
    step();
  endtask

  task automatic send(int x, int y, int l0, int l1, int l2,
                      bit expect_w);
    i_frag_valid = 1'b1;
    i_frag_x  = 10'(x);
    i_frag_y  = 10'(y);
    i_lambda0 = 21'(l0);
    i_lambda1 = 21'(l1);
    i_lambda2 = 21'(l2);
    if (expect_w)
      exp_q.push_back({19'(y * 640 + x), m_shade(l0, l1, l2)});
    step();
    i_frag_valid = 1'b0;
  endtask

  task automatic finish_tri(string name);
    bit got;
    got = 1'b0;
    i_raster_done = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (o_done) begin
        got = 1'b1;
        break;
      end
    end
    chk({name, "_done"}, 64'(got), 1);
    chk({name, "_drained"}, 64'(exp_q.size()), 0);
    chk({name, "_idle"}, 64'(o_busy), 0);
    @(negedge clk);
    chk({name, "_pulse"}, 64'(o_done), 0);
    exp_q.delete();
    step();
  endtask

  initial begin
    rst = 1'b1;
    i_tri_start = 0; i_frag_valid = 0; i_raster_done = 1;
    i_color0 = 0; i_color1 = 0; i_color2 = 0;
    i_frag_x = 0; i_frag_y = 0;
    i_lambda0 = 0; i_lambda1 = 0; i_lambda2 = 0;
    i_mem_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_state", {o_mem_valid, o_busy, o_done, o_overflow}, 0);
    step();

    // Basic write with hand-computed address/colour and latency.
    start_tri(16'hF800, 16'h07E0, 16'h001F);
    exp_q.push_back({19'd1283, 16'hF800});
    send(3, 2, 100, -5, 7, 1'b0);
    @(negedge clk);
    chk("lat_n1", 64'(o_mem_valid), 0);
    @(negedge clk);
    chk("lat_n2", 64'(o_mem_valid), 1);
    step();
    finish_tri("basic");

    // Tie between |l0| and |l1| resolves to vertex 0.
    start_tri(16'h1234, 16'h5678, 16'h9ABC);
    exp_q.push_back({19'd0, 16'h1234});
    send(0, 0, -40, 40, 10, 1'b0);
    finish_tri("tie");

    // Clipped fragments: no write, no overflow, still done.
    start_tri(16'hAAAA, 16'hBBBB, 16'hCCCC);
    send(640, 0, 1, 2, 3, 1'b0);
    send(0, 480, 1, 2, 3, 1'b0);
    finish_tri("clip");
    chk("clip_ovf", 64'(o_overflow), 0);

    // Model-driven mix including corner pixels.
    start_tri(16'h1111, 16'h2222, 16'h3333);
    send(10, 0, 1, -2, 1, 1'b1);
    send(0, 479, -3, 3, 3, 1'b1);
    send(639, 479, 5, -5, -9, 1'b1);
    send(639, 0, 0, 0, 0, 1'b1);
    send(700, 5, 9, 9, 9, 1'b0);
    send(17, 33, -2, 6, -6, 1'b1);
    finish_tri("mix");

    // Overflow: 17 of 20 survive while the port is stalled.
    i_mem_ready = 1'b0;
    start_tri(16'h0F0F, 16'hF0F0, 16'h00FF);
    for (int i = 0; i < 20; i++)
      send(i, 1, 0, -(i + 1), 0, i < 17);
    chk("ovf_flag", 64'(o_overflow), 1);
    i_mem_ready = 1'b1;
    finish_tri("ovf");
    chk("ovf_sticky", 64'(o_overflow), 1);

    // Alternating ready; the compare process checks stability.
    start_tri(16'h4444, 16'h5555, 16'h6666);
    chk("ovf_clear", 64'(o_overflow), 0);
    for (int i = 0; i < 8; i++) begin
      i_mem_ready = i[0];
      send(100 + i, 7, 3, 1, -(i - 4), 1'b1);
    end
    for (int i = 0; i < 12; i++) begin
      i_mem_ready = ~i_mem_ready;
      step();
    end
    i_mem_ready = 1'b1;
    finish_tri("stall");

    // Reset in ACTIVE abandons buffered work.
    i_mem_ready = 1'b0;
    start_tri(16'h7777, 16'h8888, 16'h9999);
    for (int i = 0; i < 5; i++)
      send(i, 9, 1, 0, 0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_state", {o_mem_valid, o_busy, o_done}, 0);
    begin
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        if (o_done || o_mem_valid) seen = 1'b1;
      end
      chk("mrst_quiet", 64'(seen), 0);
    end
    step();
    i_mem_ready = 1'b1;
    start_tri(16'hF800, 16'h07E0, 16'h001F);
    send(3, 2, 100, -5, 7, 1'b1);
    send(5, 4, -1, -50, 49, 1'b1);
    finish_tri("after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
